// File: rtl/div_unit_if.sv
// Request/response bundle between the execute stage and the divide unit.
// The pipeline side drives the request (master); the divider responds (slave).
interface div_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic [4:0]      rd_in;
    logic            kill;
    logic            busy;
    logic            rf_en;
    logic [4:0]      rd;
    logic [XLEN-1:0] wdata;

    modport master (
        output start, op, rdata1, rdata2, rd_in, kill,
        input  busy, rf_en, rd, wdata
    );

    modport slave (
        input  start, op, rdata1, rdata2, rd_in, kill,
        output busy, rf_en, rd, wdata
    );
endinterface

// File: rtl/div_unit.sv
// Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per clock. Signed operations
// divide the magnitudes and fix the signs afterwards. Divide-by-zero and the
// signed overflow case skip the iteration and answer in one cycle.
module div_unit #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]   CNT_LAST = {CW{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic            sel_rem_q, sel_rem_d;
    logic            neg_quo_q, neg_quo_d;
    logic            neg_rem_q, neg_rem_d;
    logic [4:0]      rd_lat_q, rd_lat_d;
    logic            busy_q, busy_d;
    logic            rf_en_q, rf_en_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            is_signed_s;
    logic            sign_a_s;
    logic            sign_b_s;
    logic [XLEN-1:0] abs_a_s;
    logic [XLEN-1:0] abs_b_s;
    logic            div0_s;
    logic            ovf_s;
    logic [XLEN:0]   trial_s;
    logic [XLEN-1:0] quo_fix_s;
    logic [XLEN-1:0] rem_fix_s;

    // op[0]=0 selects the signed flavours (DIV, REM)
    assign is_signed_s = ~bus.op[0];
    assign sign_a_s    = is_signed_s & bus.rdata1[XLEN-1];
    assign sign_b_s    = is_signed_s & bus.rdata2[XLEN-1];
    assign abs_a_s     = sign_a_s ? (ZERO - bus.rdata1) : bus.rdata1;
    assign abs_b_s     = sign_b_s ? (ZERO - bus.rdata2) : bus.rdata2;
    assign div0_s      = (bus.rdata2 == ZERO);
    assign ovf_s       = is_signed_s && (bus.rdata1 == MIN_NEG) && (bus.rdata2 == ALL_ONES);

    // Trial subtraction is one bit wider so a shifted-out remainder MSB is not lost
    assign trial_s     = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
    assign quo_fix_s   = neg_quo_q ? (ZERO - quo_q) : quo_q;
    assign rem_fix_s   = neg_rem_q ? (ZERO - rem_q) : rem_q;

    assign bus.busy    = busy_q;
    assign bus.rf_en   = rf_en_q;
    assign bus.rd      = rd_q;
    assign bus.wdata   = wdata_q;

    // Next-state, datapath and registered-output logic for the divider FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        sel_rem_d = sel_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rd_lat_d  = rd_lat_q;
        busy_d    = 1'b0;
        rf_en_d   = 1'b0;
        rd_d      = rd_q;
        wdata_d   = wdata_q;

        case (state_q)
            // DONE accepts a new request just like IDLE, allowing back-to-back ops
            S_IDLE, S_DONE: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else if (bus.start) begin
                    if (div0_s) begin
                        state_d = S_DONE;
                        rf_en_d = 1'b1;
                        rd_d    = bus.rd_in;
                        wdata_d = bus.op[1] ? bus.rdata1 : ALL_ONES;
                    end else if (ovf_s) begin
                        state_d = S_DONE;
                        rf_en_d = 1'b1;
                        rd_d    = bus.rd_in;
                        wdata_d = bus.op[1] ? ZERO : MIN_NEG;
                    end else begin
                        state_d   = S_DIV;
                        busy_d    = 1'b1;
                        cnt_d     = CNT_ZERO;
                        rem_d     = ZERO;
                        quo_d     = abs_a_s;
                        dvsr_d    = abs_b_s;
                        sel_rem_d = bus.op[1];
                        neg_quo_d = sign_a_s ^ sign_b_s;
                        neg_rem_d = sign_a_s;
                        rd_lat_d  = bus.rd_in;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    busy_d = 1'b1;
                    quo_d  = {quo_q[XLEN-2:0], ~trial_s[XLEN]};
                    if (trial_s[XLEN]) begin
                        rem_d = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
                    end else begin
                        rem_d = trial_s[XLEN-1:0];
                    end
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_FIX: begin
                if (bus.kill) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DONE;
                    rf_en_d = 1'b1;
                    rd_d    = rd_lat_q;
                    wdata_d = sel_rem_q ? rem_fix_s : quo_fix_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= CNT_ZERO;
            rem_q     <= ZERO;
            quo_q     <= ZERO;
            dvsr_q    <= ZERO;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_lat_q  <= 5'd0;
            busy_q    <= 1'b0;
            rf_en_q   <= 1'b0;
            rd_q      <= 5'd0;
            wdata_q   <= ZERO;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            sel_rem_q <= sel_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rd_lat_q  <= rd_lat_d;
            busy_q    <= busy_d;
            rf_en_q   <= rf_en_d;
            rd_q      <= rd_d;
            wdata_q   <= wdata_d;
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a vector table driven through a
// scoreboard queue, plus hand-written multi-cycle corner sequences.
module tb_div_unit;
    logic clk;
    logic rst;

    div_unit_if #(.XLEN(32)) bus ();

    div_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wdata;
        int          lat;
    } exp_t;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    vec_t vecs[16];
    exp_t sb[$];
    int   n_checks;
    int   n_pass;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request for a single edge and record the expected result
    task automatic issue(input bit at_once, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat);
        exp_t e;
        if (!at_once) @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rdata1 = a;
        bus.rdata2 = b;
        bus.rd_in  = rd;
        e.rd = rd;
        e.wdata = exp;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Watch outputs after the accepting edge; optionally poke start/kill/rst at cycle poke_k
    task automatic await_result(input string tag, input int bound, input int poke_k,
                                input int poke_kind, input bit expect_none, input bit exp_busy);
        bit   seen;
        bit   keep_going;
        exp_t e;
        seen = 1'b0;
        keep_going = (poke_kind != 0) || expect_none;
        for (int k = 1; k <= bound; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                chk({tag, " busy1"}, {31'd0, bus.busy}, {31'd0, exp_busy});
            end
            if (poke_k > 0 && k == poke_k + 1) begin
                bus.start = 1'b0;
                bus.kill  = 1'b0;
                rst       = 1'b0;
                if (poke_kind == 2 || poke_kind == 3) begin
                    chk({tag, " busy_after"}, {31'd0, bus.busy}, 32'd0);
                    chk({tag, " rf_en_after"}, {31'd0, bus.rf_en}, 32'd0);
                end
                if (poke_kind == 3) begin
                    chk({tag, " rd_after_rst"}, {27'd0, bus.rd}, 32'd0);
                    chk({tag, " wdata_after_rst"}, bus.wdata, 32'd0);
                end
            end
            if (poke_k > 0 && k == poke_k) begin
                case (poke_kind)
                    1: begin
                        bus.start  = 1'b1;
                        bus.op     = OP_DIVU;
                        bus.rdata1 = 32'd9;
                        bus.rdata2 = 32'd3;
                        bus.rd_in  = 5'd3;
                    end
                    2: bus.kill = 1'b1;
                    3: rst = 1'b1;
                    default: ;
                endcase
            end
            if (bus.rf_en === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL %s unexpected_rf_en: got rf_en=1 at cycle %0d want none", tag, k);
                end else begin
                    e = sb.pop_front();
                    seen = 1'b1;
                    chk({tag, " wdata"}, bus.wdata, e.wdata);
                    chk({tag, " rd"}, {27'd0, bus.rd}, {27'd0, e.rd});
                    chk({tag, " latency"}, k, e.lat);
                    chk({tag, " busy_done"}, {31'd0, bus.busy}, 32'd0);
                end
                if (!keep_going) return;
            end
        end
        if (!expect_none && !seen) begin
            n_checks++;
            $display("FAIL %s timeout: got no rf_en within %0d cycles want rf_en", tag, bound);
            sb.delete();
        end
    endtask

    initial begin
        clk        = 1'b0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rdata1 = 32'd0;
        bus.rdata2 = 32'd0;
        bus.rd_in  = 5'd0;
        bus.kill   = 1'b0;
        n_checks   = 0;
        n_pass     = 0;

        vecs[0]  = '{OP_DIV,  32'd100,        32'd7,          5'd1,  32'd14,         34};
        vecs[1]  = '{OP_REM,  32'd100,        32'd7,          5'd2,  32'd2,          34};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  34};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFF,  34};
        vecs[4]  = '{OP_DIVU, 32'hFFFF_FFFF,  32'd2,          5'd5,  32'h7FFF_FFFF,  34};
        vecs[5]  = '{OP_REMU, 32'hFFFF_FFFF,  32'd2,          5'd6,  32'd1,          34};
        vecs[6]  = '{OP_DIV,  32'd123,        32'd0,          5'd7,  32'hFFFF_FFFF,  1};
        vecs[7]  = '{OP_REMU, 32'd5,          32'd0,          5'd8,  32'd5,          1};
        vecs[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1};
        vecs[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 32'd0,          1};
        vecs[10] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'd0,          34};
        vecs[11] = '{OP_DIV,  32'h8000_0000,  32'd3,          5'd12, 32'hD555_5556,  34};
        vecs[12] = '{OP_DIV,  32'd7,          32'hFFFF_FFFD,  5'd13, 32'hFFFF_FFFE,  34};
        vecs[13] = '{OP_REM,  32'd7,          32'hFFFF_FFFD,  5'd14, 32'd1,          34};
        vecs[14] = '{OP_DIVU, 32'd1000,       32'd10,         5'd0,  32'd100,        34};
        vecs[15] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd15, 32'hFFFF_FFF9,  1};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset busy",  {31'd0, bus.busy},  32'd0);
        chk("reset rf_en", {31'd0, bus.rf_en}, 32'd0);
        chk("reset rd",    {27'd0, bus.rd},    32'd0);
        chk("reset wdata", bus.wdata,          32'd0);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);
            await_result($sformatf("vec%0d", i), 40, 0, 0, 1'b0, vecs[i].lat != 1);
        end

        // start pulsed while busy is ignored: one strobe with the first result
        issue(1'b0, OP_DIV, 32'd100, 32'd7, 5'd20, 32'd14, 34);
        await_result("start_while_busy", 80, 10, 1, 1'b0, 1'b1);

        // kill mid-operation: no strobe, then a fresh op completes normally
        issue(1'b0, OP_DIV, 32'd100, 32'd7, 5'd21, 32'd14, 34);
        sb.delete();
        await_result("kill_mid", 60, 15, 2, 1'b1, 1'b1);
        issue(1'b0, OP_DIVU, 32'd9, 32'd3, 5'd22, 32'd3, 34);
        await_result("after_kill", 40, 0, 0, 1'b0, 1'b1);

        // back-to-back: new request accepted in the DONE cycle
        issue(1'b0, OP_REMU, 32'd17, 32'd5, 5'd23, 32'd2, 34);
        await_result("b2b_first", 40, 0, 0, 1'b0, 1'b1);
        issue(1'b1, OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd24, 32'hFFFF_FFF2, 34);
        await_result("b2b_second", 40, 0, 0, 1'b0, 1'b1);

        // kill with start in the DONE cycle: strobe stays this cycle, start is dropped
        issue(1'b1, OP_DIVU, 32'd9, 32'd3, 5'd25, 32'd3, 34);
        await_result("kill_done_op", 40, 0, 0, 1'b0, 1'b1);
        bus.kill   = 1'b1;
        bus.start  = 1'b1;
        bus.op     = OP_DIVU;
        bus.rdata1 = 32'd50;
        bus.rdata2 = 32'd5;
        bus.rd_in  = 5'd26;
        @(negedge clk);
        bus.kill  = 1'b0;
        bus.start = 1'b0;
        chk("kill_done rf_en", {31'd0, bus.rf_en}, 32'd0);
        chk("kill_done busy",  {31'd0, bus.busy},  32'd0);
        await_result("kill_done_quiet", 40, 0, 0, 1'b1, 1'b0);

        // synchronous reset mid-operation clears everything
        issue(1'b0, OP_DIV, 32'd100, 32'd7, 5'd27, 32'd14, 34);
        sb.delete();
        await_result("rst_mid", 60, 20, 3, 1'b1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
